// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - byte FIFO feeding an 8N1 UART transmitter
// Frames run back to back whenever the FIFO holds data at the end of a stop bit.
module uart_tx_buffered #(
    parameter int CLK_DIV         = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                din,
    input  logic                       we,
    output logic                       txd,
    output logic                       busy,
    output logic                       full,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] RELOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           bit_end;
    logic           unused_din;

    assign unused_din = ^din[31:8];
    assign full       = (level == LVL_MAX);
    assign push       = we && !full;
    assign bit_end    = (cnt == '0);
    // A byte pushed into an empty FIFO is not visible to pop until the next edge.
    assign pop        = (level != '0) && ((state == IDLE) || (state == STOP && bit_end));
    assign busy       = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (we && full)
                overflow <= 1'b1;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        txd   <= 1'b0;
                        cnt   <= RELOAD;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shift[0];
                        cnt     <= RELOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            txd   <= 1'b0;
                            cnt   <= RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed checks of uart_tx_buffered with CLK_DIV=4, depth 4
module tb_uart_tx_buffered;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        we;
    logic        txd;
    logic        busy;
    logic        full;
    logic [2:0]  level;
    logic        overflow;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         mon_err = 0;
    logic       mon_abort;

    uart_tx_buffered #(.CLK_DIV(CD), .FIFO_DEPTH_LOG2(2)) dut (
        .clk(clk), .reset(reset), .din(din), .we(we), .txd(txd),
        .busy(busy), .full(full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (reset) mon_abort = 1'b1;
        end
    endtask

    // Receiver model: samples the middle of every bit after a falling edge.
    always begin
        logic [7:0] b;
        logic st, sp;
        int t0;
        @(negedge clk);
        if (!reset && txd === 1'b0) begin
            mon_abort = 1'b0;
            t0 = cyc;
            mon_wait(2);
            st = txd;
            for (int j = 0; j < 8; j++) begin
                mon_wait(CD);
                b[j] = txd;
            end
            mon_wait(CD);
            sp = txd;
            if (!mon_abort) begin
                rx_q.push_back(b);
                rx_t.push_back(t0);
                if (st !== 1'b0 || sp !== 1'b1) mon_err++;
            end
            mon_wait(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write_byte(input logic [31:0] d);
        din = d;
        we  = 1'b1;
        tick();
        we  = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
        tick();
        tick();
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] f;
        for (int i = 0; i < 40; i++)
            f[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
        return f;
    endfunction

    initial begin
        logic [39:0] obs;
        logic [7:0]  wexp [10];
        int          bcnt;
        logic        stayed_high;

        reset = 1'b1;
        we    = 1'b0;
        din   = '0;
        tick();
        tick();
        check("rst_txd", {63'd0, txd}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_level", {61'd0, level}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        tick();

        // single byte 0x41, exact per-cycle waveform
        write_byte(32'h0000_0041);
        check("s_txd_e0", {63'd0, txd}, 64'd1);
        check("s_level_e0", {61'd0, level}, 64'd1);
        bcnt = busy ? 1 : 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            obs[i] = txd;
            bcnt += busy ? 1 : 0;
            tick();
        end
        check("s_frame", {24'd0, obs}, {24'd0, 40'b1111_0000_1111_0000_0000_0000_0000_0000_1111_0000});
        check("s_busy_cycles", 64'(bcnt), 64'd41);
        check("s_busy_end", {63'd0, busy}, 64'd0);
        check("s_level_end", {61'd0, level}, 64'd0);
        tick();
        check("s_rx_byte", {56'd0, rx_q[0]}, 64'h41);
        rx_q.delete();
        rx_t.delete();

        // back-to-back 0x55, 0xAA, 0x0F
        we = 1'b1;
        din = 32'h55; tick();
        check("b_level1", {61'd0, level}, 64'd1);
        din = 32'hAA; tick();
        check("b_level2", {61'd0, level}, 64'd1);
        din = 32'h0F; tick();
        check("b_level3", {61'd0, level}, 64'd2);
        we = 1'b0;
        repeat (38) tick();
        check("b_level_pre_boundary", {61'd0, level}, 64'd2);
        tick();
        check("b_level_boundary1", {61'd0, level}, 64'd1);
        repeat (40) tick();
        check("b_level_boundary2", {61'd0, level}, 64'd0);
        wait_idle(200, "b_idle_timeout");
        check("b_rx_count", 64'(rx_q.size()), 64'd3);
        check("b_rx0", {56'd0, rx_q[0]}, 64'h55);
        check("b_rx1", {56'd0, rx_q[1]}, 64'hAA);
        check("b_rx2", {56'd0, rx_q[2]}, 64'h0F);
        check("b_gap01", 64'(rx_t[1] - rx_t[0]), 64'd40);
        check("b_gap12", 64'(rx_t[2] - rx_t[1]), 64'd40);
        rx_q.delete();
        rx_t.delete();

        // overflow: six consecutive writes into a depth-4 FIFO
        we = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            din = 32'(i * 8'h11);
            tick();
            if (i == 2) check("o_level_after_pop", {61'd0, level}, 64'd1);
            if (i == 4) check("o_full_before", {63'd0, full}, 64'd0);
            if (i == 5) begin
                check("o_full_5", {63'd0, full}, 64'd1);
                check("o_level_5", {61'd0, level}, 64'd4);
                check("o_ovf_5", {63'd0, overflow}, 64'd0);
            end
        end
        we = 1'b0;
        check("o_ovf_6", {63'd0, overflow}, 64'd1);
        check("o_level_6", {61'd0, level}, 64'd4);
        wait_idle(400, "o_idle_timeout");
        check("o_rx_count", 64'(rx_q.size()), 64'd5);
        check("o_rx_order", {24'd0, rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, 64'h11_22_33_44_55);
        check("o_ovf_sticky", {63'd0, overflow}, 64'd1);
        rx_q.delete();
        rx_t.delete();

        // upper data bits ignored
        write_byte(32'hDEADBE33);
        wait_idle(100, "u_idle_timeout");
        check("u_rx_byte", {56'd0, rx_q[0]}, 64'h33);
        rx_q.delete();
        rx_t.delete();

        // reset during data bit 3 with two bytes queued
        we = 1'b1;
        din = 32'hC3; tick();
        din = 32'h3C; tick();
        din = 32'h99; tick();
        we = 1'b0;
        check("r_level_queued", {61'd0, level}, 64'd2);
        repeat (16) tick();
        #2 reset = 1'b1;
        #1;
        check("r_txd_async", {63'd0, txd}, 64'd1);
        check("r_busy_async", {63'd0, busy}, 64'd0);
        check("r_level_async", {61'd0, level}, 64'd0);
        check("r_ovf_async", {63'd0, overflow}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        stayed_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        check("r_line_idle", {63'd0, stayed_high}, 64'd1);
        check("r_no_frames", 64'(rx_q.size()), 64'd0);
        rx_q.delete();
        rx_t.delete();

        // wrap-around: 10 writes paced one per frame
        for (int i = 0; i < 10; i++) begin
            wexp[i] = 8'(i * 8'h13 + 8'h07);
            write_byte({24'h0, wexp[i]});
            repeat (39) tick();
        end
        wait_idle(200, "w_idle_timeout");
        check("w_rx_count", 64'(rx_q.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("w_rx%0d", i), {56'd0, rx_q[i]}, {56'd0, wexp[i]});
        check("w_ovf_clear", {63'd0, overflow}, 64'd0);
        check("w_level_end", {61'd0, level}, 64'd0);
        check("mon_framing_errors", 64'(mon_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
